// File: rtl/ss_scan_controller.sv
// ss_scan_controller: multiplexes four 7-segment hex digits.
// Each digit slot is a BLANK period followed by a DRIVE period. New display data
// waits in a pending register and is applied only at the frame boundary.
// Ports:
//   clk, reset_n                   clock and asynchronous active-low reset
//   value, dp_in, digit_en, load   display data and its one-cycle capture request
//   load_ack, pending              apply pulse, and a flag for data waiting to be applied
//   ss_anode, ss_cathode           active-low digit selects and segments (DP,G..A)
//   digit_idx                      index of the digit whose slot is current
module ss_scan_controller #(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  input  logic        load,
  output logic        load_ack,
  output logic        pending,
  output logic [3:0]  ss_anode,
  output logic [7:0]  ss_cathode,
  output logic [1:0]  digit_idx
);
  typedef enum logic {BLANK, DRIVE} state_t;
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  state_t      state, state_nx;
  logic [31:0] tick, tick_nx;
  logic [1:0]  idx_nx;
  logic [15:0] act_val, act_val_nx, pend_val;
  logic [3:0]  act_dp, act_dp_nx, pend_dp;
  logic [3:0]  act_en, act_en_nx, pend_en;
  logic        boundary, lit;
  logic [3:0]  nib, anode_nx;
  logic [7:0]  cathode_nx;
  assign boundary = state == DRIVE && tick == 32'(TICKS_PER_DIGIT - 1) && digit_idx == 2'd3;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= BLANK;
      tick       <= '0;
      digit_idx  <= '0;
      act_val    <= '0;
      act_dp     <= '0;
      act_en     <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_en    <= '0;
      pending    <= 1'b0;
      load_ack   <= 1'b0;
      ss_anode   <= 4'hF;
      ss_cathode <= 8'hFF;
    end else begin
      state      <= state_nx;
      tick       <= tick_nx;
      digit_idx  <= idx_nx;
      act_val    <= act_val_nx;
      act_dp     <= act_dp_nx;
      act_en     <= act_en_nx;
      load_ack   <= boundary && pending;
      pending    <= load || (pending && !boundary);
      ss_anode   <= anode_nx;
      ss_cathode <= cathode_nx;
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
        pend_en  <= digit_en;
      end
    end
  always_comb begin
    state_nx   = state;
    tick_nx    = tick + 32'd1;
    idx_nx     = digit_idx;
    if (state == BLANK && tick == 32'(BLANK_TICKS - 1)) begin
      state_nx = DRIVE;
      tick_nx  = '0;
    end else if (state == DRIVE && tick == 32'(TICKS_PER_DIGIT - 1)) begin
      state_nx = BLANK;
      tick_nx  = '0;
      idx_nx   = digit_idx + 2'd1;
    end
    act_val_nx = (boundary && pending) ? pend_val : act_val;
    act_dp_nx  = (boundary && pending) ? pend_dp  : act_dp;
    act_en_nx  = (boundary && pending) ? pend_en  : act_en;
  end
  // Outputs are computed from next-state values so the registered outputs line up with the state.
  always_comb begin
    nib        = act_val_nx[{idx_nx, 2'b00} +: 4];
    lit        = state_nx == DRIVE && act_en_nx[idx_nx];
    anode_nx   = lit ? ~(4'b0001 << idx_nx) : 4'hF;
    cathode_nx = lit ? {~act_dp_nx[idx_nx], SEG[nib]} : 8'hFF;
  end
endmodule

// File: tb/tb_ss_scan_controller.sv
// tb_ss_scan_controller: random and directed loads checked against a frame-position model.
module tb_ss_scan_controller;
  localparam int TPD = 4, BT = 2, SLOT = TPD + BT, FRAME = 4 * SLOT;
  logic        clk = 1'b0, reset_n = 1'b0, load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0, digit_en = '0;
  logic        load_ack, pending;
  logic [3:0]  ss_anode;
  logic [7:0]  ss_cathode;
  logic [1:0]  digit_idx;
  ss_scan_controller #(.TICKS_PER_DIGIT(TPD), .BLANK_TICKS(BT)) dut (
    .clk(clk), .reset_n(reset_n), .value(value), .dp_in(dp_in), .digit_en(digit_en),
    .load(load), .load_ack(load_ack), .pending(pending), .ss_anode(ss_anode),
    .ss_cathode(ss_cathode), .digit_idx(digit_idx)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [15:0] m_val = '0, p_val = '0;
  logic [3:0]  m_dp = '0, m_en = '0, p_dp = '0, p_en = '0;
  bit          p_valid = 0, anchored = 0;
  int          cnt = 0;
  int          ack_q[$];
  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endfunction
  task automatic chk_dark(input string tag);
    chk({tag, " anode"}, 32'(ss_anode), 32'hF);
    chk({tag, " cathode"}, 32'(ss_cathode), 32'hFF);
    chk({tag, " digit_idx"}, 32'(digit_idx), 0);
    chk({tag, " pending"}, 32'(pending), 0);
    chk({tag, " load_ack"}, 32'(load_ack), 0);
  endtask
  // Monitor: cycle position within the frame is counted from the first 0->1 digit_idx step.
  initial begin
    int p, slot, w;
    bit lit, exp_ack;
    logic [3:0] exp_an;
    logic [7:0] exp_ca;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_val = '0; m_dp = '0; m_en = '0; p_valid = 0; anchored = 0;
        ack_q.delete();
        chk_dark("reset");
      end else if (!anchored && digit_idx != 2'd1) begin
        chk_dark("startup");
      end else begin
        if (!anchored) begin
          anchored = 1;
          cnt = SLOT;
        end
        p = cnt % FRAME;
        slot = p / SLOT;
        w = p % SLOT;
        lit = w >= BT && m_en[slot];
        exp_an = lit ? ~(4'b0001 << slot) : 4'hF;
        exp_ca = lit ? {~m_dp[slot], seg_tab[m_val[slot*4 +: 4]]} : 8'hFF;
        chk("digit_idx", 32'(digit_idx), 32'(slot));
        chk("anode", 32'(ss_anode), 32'(exp_an));
        chk("cathode", 32'(ss_cathode), 32'(exp_ca));
        chk("pending", 32'(pending), 32'(p_valid));
        exp_ack = ack_q.size() > 0 && ack_q[0] == cnt;
        chk("load_ack", 32'(load_ack), 32'(exp_ack));
        if (exp_ack) void'(ack_q.pop_front());
        if (p == FRAME - 1 && p_valid) begin
          m_val = p_val; m_dp = p_dp; m_en = p_en; p_valid = 0;
        end
        if (load) begin
          if (!p_valid) ack_q.push_back(p == FRAME - 1 ? cnt + 1 + FRAME : cnt + FRAME - p);
          p_val = value; p_dp = dp_in; p_en = digit_en; p_valid = 1;
        end
        cnt++;
      end
    end
  end
  task automatic tick_();
    @(posedge clk);
    #1;
  endtask
  task automatic do_load(input logic [15:0] v, input logic [3:0] e, input logic [3:0] d);
    value = v; digit_en = e; dp_in = d; load = 1'b1;
    tick_();
    load = 1'b0;
  endtask
  task automatic wait_pos(input int target);
    int n = 0;
    while (!(anchored && cnt % FRAME == target) && n < 200) begin
      tick_();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_pos timeout: got no position %0d expected within 200 cycles", target);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected within 2 ms");
    $fatal(1);
  end
  initial begin
    repeat (3) tick_();
    reset_n = 1'b1;
    repeat (100) tick_();
    wait_pos(8);  do_load(16'h12AD, 4'hF, 4'b0001);
    repeat (60) tick_();
    wait_pos(3);  do_load(16'h1111, 4'hF, 4'h0);
    wait_pos(10); do_load(16'h2222, 4'hF, 4'h0);
    repeat (50) tick_();
    wait_pos(5);  do_load(16'h3333, 4'hF, 4'b1010);
    wait_pos(23); do_load(16'h4444, 4'hF, 4'h0);
    repeat (60) tick_();
    wait_pos(23); do_load(16'h5A5A, 4'b0101, 4'hF);
    repeat (60) tick_();
    repeat (40) begin
      repeat ($urandom_range(0, 30)) tick_();
      do_load(16'($urandom), 4'($urandom), 4'($urandom));
    end
    repeat (60) tick_();
    wait_pos(3);  do_load(16'hBEEF, 4'hF, 4'hF);
    wait_pos(15);
    reset_n = 1'b0;
    #1;
    chk("async reset anode", 32'(ss_anode), 32'hF);
    chk("async reset cathode", 32'(ss_cathode), 32'hFF);
    chk("async reset pending", 32'(pending), 0);
    chk("async reset digit_idx", 32'(digit_idx), 0);
    repeat (3) tick_();
    reset_n = 1'b1;
    repeat (80) tick_();
    chk("acks outstanding", 32'(ack_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
